// File: rtl/jtdsp16_pkg.sv
// Shared types and constants for the JTDSP16 serial input port.
package jtdsp16_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } sio_state_t;

  localparam int WLEN16 = 16;
  localparam int WLEN8  = 8;

  localparam logic [3:0] LAST16 = 4'(WLEN16 - 1);
  localparam logic [3:0] LAST8  = 4'(WLEN8 - 1);

  // MSB-first enters at bit 0 and moves up; LSB-first enters at bit 15 and moves down.
  function automatic logic [15:0] shift_in(input logic [15:0] sr, input logic b,
                                           input logic msb);
    return msb ? {sr[14:0], b} : {b, sr[15:1]};
  endfunction

endpackage

// File: rtl/jtdsp16_sync.sv
// Input synchroniser: two flops when JTDSP16_SIO_RX_SYNC_EN is defined,
// otherwise a single register for inputs already in the clk domain.
module jtdsp16_sync #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] s1_q, s1_d;

  always_comb s1_d = d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) s1_q <= '0;
    else        s1_q <= s1_d;
  end

`ifdef JTDSP16_SIO_RX_SYNC_EN
  logic [W-1:0] s2_q, s2_d;

  always_comb s2_d = s1_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) s2_q <= '0;
    else        s2_q <= s2_d;
  end

  assign q = s2_q;
`else
  assign q = s1_q;
`endif

endmodule

// File: rtl/jtdsp16_sio_rx.sv
// JTDSP16 serial input receiver: ick/ild/di framing into the sdx buffer with ibf/ovr.
// Synchroniser depth selected by JTDSP16_SIO_RX_SYNC_EN.
module jtdsp16_sio_rx
  import jtdsp16_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cen,
  input  logic        di,
  input  logic        ick,
  input  logic        ild,
  input  logic        ilen,
  input  logic        msb_first,
  input  logic        sdx_rd,
  output logic [15:0] sdx_in,
  output logic        ibf,
  output logic        ovr,
  output logic        dbg_shift
);

  logic [2:0] sync_q;
  logic       ick_s, ild_s, di_s;

  jtdsp16_sync #(.W(3)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     ({ick, ild, di}),
    .q     (sync_q)
  );

  assign {ick_s, ild_s, di_s} = sync_q;

  sio_state_t  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] sr_q, sr_d;
  logic        len8_q, len8_d;
  logic        msb_q, msb_d;
  logic        done_q, done_d;
  logic        ick_last_q, ick_last_d;
  logic        rd_pend_q, rd_pend_d;
  logic [15:0] sdx_q, sdx_d;
  logic        ibf_q, ibf_d;
  logic        ovr_q, ovr_d;

  logic        rise;
  logic [3:0]  last_bit;
  logic [15:0] word;

  assign rise     = cen & ick_s & ~ick_last_q;
  assign last_bit = len8_q ? LAST8 : LAST16;
  // An 8-bit LSB-first word ends up in the upper byte of the shifter.
  assign word     = !len8_q ? sr_q : (msb_q ? {8'h00, sr_q[7:0]} : {8'h00, sr_q[15:8]});

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sr_d       = sr_q;
    len8_d     = len8_q;
    msb_d      = msb_q;
    done_d     = done_q;
    ick_last_d = ick_last_q;
    rd_pend_d  = rd_pend_q | sdx_rd;
    sdx_d      = sdx_q;
    ibf_d      = ibf_q;
    ovr_d      = ovr_q;

    if (cen) begin
      ick_last_d = ick_s;
      done_d     = 1'b0;
    end

    if (rise) begin
      if (ild_s) begin
        len8_d  = ilen;
        msb_d   = msb_first;
        sr_d    = shift_in(16'h0000, di_s, msb_first);
        cnt_d   = 4'd1;
        state_d = ST_SHIFT;
      end else if (state_q == ST_SHIFT) begin
        sr_d = shift_in(sr_q, di_s, msb_q);
        if (cnt_q == last_bit) begin
          cnt_d   = 4'd0;
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
    end

    // A read pending or arriving in the completion cycle is absorbed by the new word.
    if (cen) begin
      if (done_q) begin
        sdx_d     = word;
        ibf_d     = 1'b1;
        rd_pend_d = 1'b0;
        if (!(rd_pend_q | sdx_rd) && ibf_q) ovr_d = 1'b1;
      end else if (rd_pend_q) begin
        ibf_d     = 1'b0;
        ovr_d     = 1'b0;
        rd_pend_d = sdx_rd;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      sr_q       <= 16'h0000;
      len8_q     <= 1'b0;
      msb_q      <= 1'b0;
      done_q     <= 1'b0;
      ick_last_q <= 1'b0;
      rd_pend_q  <= 1'b0;
      sdx_q      <= 16'h0000;
      ibf_q      <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sr_q       <= sr_d;
      len8_q     <= len8_d;
      msb_q      <= msb_d;
      done_q     <= done_d;
      ick_last_q <= ick_last_d;
      rd_pend_q  <= rd_pend_d;
      sdx_q      <= sdx_d;
      ibf_q      <= ibf_d;
      ovr_q      <= ovr_d;
    end
  end

  assign sdx_in    = sdx_q;
  assign ibf       = ibf_q;
  assign ovr       = ovr_q;
  assign dbg_shift = (state_q == ST_SHIFT);

endmodule

// File: tb/tb_jtdsp16_sio_rx.sv
// Directed bench for jtdsp16_sio_rx: framing, bit order, length, overrun, restart, reset.
module tb_jtdsp16_sio_rx;

`ifdef JTDSP16_SIO_RX_SYNC_EN
  localparam int SYNC_EXTRA = 1;
`else
  localparam int SYNC_EXTRA = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, cen, di, ick, ild, ilen, msb_first, sdx_rd;
  logic [15:0] sdx_in;
  logic        ibf, ovr, dbg_shift;

  int checks = 0;
  int errors = 0;

  jtdsp16_sio_rx dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cen       (cen),
    .di        (di),
    .ick       (ick),
    .ild       (ild),
    .ilen      (ilen),
    .msb_first (msb_first),
    .sdx_rd    (sdx_rd),
    .sdx_in    (sdx_in),
    .ibf       (ibf),
    .ovr       (ovr),
    .dbg_shift (dbg_shift)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b, input logic l);
    di  = b;
    ild = l;
    ick = 1'b0;
    tick(2);
    ick = 1'b1;
    tick(2);
  endtask

  // Returns in the completion cycle; the word is visible one cycle later.
  task automatic send_word(input logic [15:0] v, input int n, input logic msb);
    logic b;
    ilen      = (n == 8);
    msb_first = msb;
    for (int i = 0; i < n; i++) begin
      b = msb ? v[n-1-i] : v[i];
      send_bit(b, i == 0);
    end
    ild = 1'b0;
    tick(SYNC_EXTRA);
  endtask

  task automatic do_read();
    sdx_rd = 1'b1;
    tick(1);
    sdx_rd = 1'b0;
    tick(1);
  endtask

  initial begin
    logic [15:0] cafe;
    cafe = 16'hCAFE;
    rst_n = 1'b0; cen = 1'b1; di = 1'b0; ick = 1'b0; ild = 1'b0;
    ilen = 1'b0; msb_first = 1'b1; sdx_rd = 1'b0;
    tick(3);
    check("rst_sdx", sdx_in, 16'h0000);
    check("rst_ibf", {15'b0, ibf}, 16'd0);
    check("rst_ovr", {15'b0, ovr}, 16'd0);
    check("rst_state", {15'b0, dbg_shift}, 16'd0);
    rst_n = 1'b1;
    tick(2);

    send_word(16'hA53C, 16, 1'b1);
    check("a53c_ibf_early", {15'b0, ibf}, 16'd0);
    tick(1);
    check("a53c_ibf", {15'b0, ibf}, 16'd1);
    check("a53c_sdx", sdx_in, 16'hA53C);
    check("a53c_ovr", {15'b0, ovr}, 16'd0);
    do_read();
    check("a53c_rd_ibf", {15'b0, ibf}, 16'd0);
    check("a53c_rd_hold", sdx_in, 16'hA53C);

    send_word(16'h0081, 8, 1'b0);
    tick(1);
    check("b81_sdx", sdx_in, 16'h0081);
    check("b81_ibf", {15'b0, ibf}, 16'd1);
    do_read();
    send_word(16'h0035, 8, 1'b0);
    tick(1);
    check("b35_lsb8", sdx_in, 16'h0035);
    do_read();
    send_word(16'h00C4, 8, 1'b1);
    tick(1);
    check("bc4_msb8", sdx_in, 16'h00C4);
    do_read();
    send_word(16'h1357, 16, 1'b0);
    tick(1);
    check("w1357_lsb16", sdx_in, 16'h1357);
    do_read();

    send_word(16'h1234, 16, 1'b1);
    tick(1);
    check("w1234_ovr", {15'b0, ovr}, 16'd0);
    send_word(16'h5678, 16, 1'b1);
    tick(1);
    check("ovr_sdx", sdx_in, 16'h5678);
    check("ovr_set", {15'b0, ovr}, 16'd1);
    check("ovr_ibf", {15'b0, ibf}, 16'd1);
    do_read();
    check("ovr_rd_ibf", {15'b0, ibf}, 16'd0);
    check("ovr_rd_ovr", {15'b0, ovr}, 16'd0);

    send_word(16'h1111, 16, 1'b1);
    tick(1);
    check("w1111_ibf", {15'b0, ibf}, 16'd1);
    send_word(16'hBEEF, 16, 1'b1);
    sdx_rd = 1'b1;
    tick(1);
    sdx_rd = 1'b0;
    check("coin_sdx", sdx_in, 16'hBEEF);
    check("coin_ibf", {15'b0, ibf}, 16'd1);
    check("coin_ovr", {15'b0, ovr}, 16'd0);
    tick(3);
    check("coin_ibf_hold", {15'b0, ibf}, 16'd1);
    do_read();
    check("coin_rd_ibf", {15'b0, ibf}, 16'd0);

    for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
    tick(3);
    check("noild_ibf", {15'b0, ibf}, 16'd0);
    check("noild_state", {15'b0, dbg_shift}, 16'd0);

    ilen = 1'b0; msb_first = 1'b1;
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    check("restart_busy", {15'b0, dbg_shift}, 16'd1);
    send_word(16'h00FF, 16, 1'b1);
    tick(1);
    check("restart_sdx", sdx_in, 16'h00FF);

    ilen = 1'b0; msb_first = 1'b1;
    for (int i = 0; i < 9; i++) send_bit(cafe[15-i], i == 0);
    rst_n = 1'b0;
    #2;
    check("midrst_ibf", {15'b0, ibf}, 16'd0);
    check("midrst_sdx", sdx_in, 16'h0000);
    tick(2);
    rst_n = 1'b1;
    tick(2);
    for (int i = 9; i < 16; i++) send_bit(cafe[15-i], 1'b0);
    tick(3);
    check("midrst_tail_ibf", {15'b0, ibf}, 16'd0);
    send_word(16'hCAFE, 16, 1'b1);
    tick(1);
    check("cafe_sdx", sdx_in, 16'hCAFE);
    check("cafe_ibf", {15'b0, ibf}, 16'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jtdsp16_sio_rx.md
JTDSP16_SIO_RX -- requirements
Module: jtdsp16_sio_rx

Interface
REQ-001 SHALL have port: clk  input  1  system clock; all state changes on rising edge.
REQ-002 SHALL have port: rst_n  input  1  reset, asynchronous assertion, active-low.
REQ-003 SHALL have port: cen  input  1  DSP clock enable; logic advances only when high, apart from reset.
REQ-004 SHALL have port: di  input  1  serial data input.
REQ-005 SHALL have port: ick  input  1  serial input clock, asynchronous to clk; di sampled on its rising edge.
REQ-006 SHALL have port: ild  input  1  input load; high at an ick rise marks the first bit of a word.
REQ-007 SHALL have port: ilen  input  1  word length; 0 = 16 bits, 1 = 8 bits.
REQ-008 SHALL have port: msb_first  input  1  bit order; 1 = MSB first, 0 = LSB first.
REQ-009 SHALL have port: sdx_rd  input  1  one-cycle CPU read strobe of the sdx input buffer.
REQ-010 SHALL have port: sdx_in  output  16  received word buffer.
REQ-011 SHALL have port: ibf  output  1  input buffer full.
REQ-012 SHALL have port: ovr  output  1  sticky overrun flag.

Function
REQ-013 SHALL detect ick rising edges from the synchronised ick sampled on cen cycles, producing one strobe per edge.
REQ-014 SHALL be able to start a word only when an ick rise occurs with ild high; a rise with ild low and no word in progress is ignored.
REQ-015 SHALL use states IDLE and SHIFT: IDLE->SHIFT on an ild-qualified rise; SHIFT->IDLE when the last bit is captured.
REQ-016 SHALL shift di into a 16-bit shift register on every ick rise in SHIFT and on the starting rise, with a bit counter 0..N-1 (N = 16 or 8).
REQ-017 SHALL shift left for MSB-first and right for LSB-first; in 8-bit mode the result is placed in sdx_in[7:0] with sdx_in[15:8] = 0.
REQ-018 SHALL restart the word when ild is high at a rise during SHIFT: counter reset, partial bits discarded, the current bit becomes bit 0.
REQ-019 SHALL transfer the completed word to sdx_in and set ibf on the cen cycle after the last bit's rise (latency 1 cen).
REQ-020 SHALL clear ibf on the cen cycle after sdx_rd; sdx_in holds its value.
REQ-021 SHALL, on completion while ibf=1 and no sdx_rd, overwrite sdx_in and set ovr; ovr clears only on sdx_rd.
REQ-022 SHALL, when completion and sdx_rd coincide, load the new word, keep ibf=1, and leave ovr unchanged.
REQ-023 SHALL sample ilen and msb_first at word start and hold them for the rest of the word.

Reset
REQ-024 SHALL on rst_n low force sdx_in=0, ibf=0, ovr=0, state IDLE, counter 0, shift register 0, and edge-detector history 0.
REQ-025 SHALL discard any partial word on reset mid-word; after release, reception requires a new ild-qualified rise.

Configuration
REQ-026 SHALL provide macro JTDSP16_SIO_RX_SYNC_EN: when defined, ick, ild and di pass through two-flop synchronisers; when undefined, one register stage is used, for ick generated in the clk domain. Edge latency drops by one clk.

Structure
REQ-027 SHALL place the state encoding (IDLE/SHIFT) and word-length constants (16, 8) in the shared package jtdsp16_pkg.
REQ-028 SHALL implement the synchroniser as sub-module jtdsp16_sync (parametric width, depth set by JTDSP16_SIO_RX_SYNC_EN).

Verification
REQ-029 SHALL check: ilen=0, msb_first=1, send 0xA53C with ild on the first rise -> sdx_in=0xA53C, ibf=1 one cen after the 16th rise.
REQ-030 SHALL check: ilen=1, msb_first=0, send bits of 0x81 LSB first -> sdx_in=0x0081, ibf=1.
REQ-031 SHALL check: two words 0x1234 then 0x5678 with no sdx_rd -> sdx_in=0x5678, ovr=1; sdx_rd -> ibf=0, ovr=0.
REQ-032 SHALL check: sdx_rd in the completion cycle of 0xBEEF -> ibf=1, ovr=0, sdx_in=0xBEEF.
REQ-033 SHALL check: ild reasserted after 5 bits, then 0x00FF sent -> sdx_in=0x00FF.
REQ-034 SHALL check: rst_n pulsed after 9 bits, then a full 0xCAFE sent -> ibf=0 during reset, final sdx_in=0xCAFE.
